// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, ALUOp classes and the control
// bundle that travels down the ID/EX, EX/MEM and MEM/WB registers.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// is read by the instruction currently in decode.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int ADDR_W = RA_W
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              stall_o
);

  always_comb begin
    stall_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) &
              ((ex_rd_i == rs1_i) | (ex_rd_i == rs2_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass into the captured operands,
// load-use stall generation, bubble insertion on stall/flush and a stall counter.
module id_ex_stage
  import riscv_pkg::ctrl_t;
  import riscv_pkg::CTRL_NOP;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int RA_W  = riscv_pkg::RA_W,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC_in,
  input  logic [RA_W-1:0]  rs1,
  input  logic [RA_W-1:0]  rs2,
  input  logic [RA_W-1:0]  rd,
  input  logic [XLEN-1:0]  Read_Data_1,
  input  logic [XLEN-1:0]  Read_Data_2,
  input  logic [XLEN-1:0]  Imm,
  input  logic [3:0]       Funct4,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic             Branch,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic             WB_RegWrite,
  input  logic [RA_W-1:0]  WB_rd,
  input  logic [XLEN-1:0]  WB_Data,
  input  logic             Flush,
  output logic [XLEN-1:0]  EX_PC,
  output logic [XLEN-1:0]  EX_Data_1,
  output logic [XLEN-1:0]  EX_Data_2,
  output logic [XLEN-1:0]  EX_Imm,
  output logic [RA_W-1:0]  EX_rs1,
  output logic [RA_W-1:0]  EX_rs2,
  output logic [RA_W-1:0]  EX_rd,
  output logic [3:0]       EX_Funct4,
  output logic [1:0]       EX_ALUOp,
  output logic             EX_RegWrite,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic             EX_MemtoReg,
  output logic             EX_Branch,
  output logic             EX_ALUSrc,
  output logic             EX_valid,
  output logic             Stall,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic [CNT_W-1:0] Stall_Count
);

  logic [XLEN-1:0]  pc_q, pc_d, data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [RA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]       funct4_q, funct4_d;
  ctrl_t            ctrl_q, ctrl_d, ctrl_in;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  // The register file writes on the same edge we capture, so its read port
  // still shows the old value; take the writeback data directly instead.
  function automatic logic [XLEN-1:0] operand_sel(
    input logic [RA_W-1:0] rs_a,
    input logic [XLEN-1:0] rf_data
  );
    if (rs_a == '0)
      return '0;
    else if (WB_RegWrite && (WB_rd == rs_a))
      return WB_Data;
    else
      return rf_data;
  endfunction

  hazard_detect #(.ADDR_W(RA_W)) u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .stall_o       (stall)
  );

  always_comb begin
    ctrl_in = '{reg_write:  RegWrite,
                mem_read:   MemRead,
                mem_write:  MemWrite,
                mem_to_reg: MemtoReg,
                branch:     Branch,
                alu_src:    ALUSrc,
                alu_op:     ALUOp};

    pc_d     = '0;
    data1_d  = '0;
    data2_d  = '0;
    imm_d    = '0;
    rs1_d    = '0;
    rs2_d    = '0;
    rd_d     = '0;
    funct4_d = '0;
    ctrl_d   = CTRL_NOP;
    valid_d  = 1'b0;

    // Flush and stall both leave an all-zero bubble behind.
    if (!Flush && !stall) begin
      pc_d     = PC_in;
      data1_d  = operand_sel(rs1, Read_Data_1);
      data2_d  = operand_sel(rs2, Read_Data_2);
      imm_d    = Imm;
      rs1_d    = rs1;
      rs2_d    = rs2;
      rd_d     = rd;
      funct4_d = Funct4;
      ctrl_d   = ctrl_in;
      valid_d  = 1'b1;
    end

    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      funct4_q    <= '0;
      ctrl_q      <= CTRL_NOP;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      funct4_q    <= funct4_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign EX_PC       = pc_q;
  assign EX_Data_1   = data1_q;
  assign EX_Data_2   = data2_q;
  assign EX_Imm      = imm_q;
  assign EX_rs1      = rs1_q;
  assign EX_rs2      = rs2_q;
  assign EX_rd       = rd_q;
  assign EX_Funct4   = funct4_q;
  assign EX_ALUOp    = ctrl_q.alu_op;
  assign EX_RegWrite = ctrl_q.reg_write;
  assign EX_MemRead  = ctrl_q.mem_read;
  assign EX_MemWrite = ctrl_q.mem_write;
  assign EX_MemtoReg = ctrl_q.mem_to_reg;
  assign EX_Branch   = ctrl_q.branch;
  assign EX_ALUSrc   = ctrl_q.alu_src;
  assign EX_valid    = valid_q;
  assign Stall       = stall;
  assign PC_Write    = ~stall;
  assign IF_ID_Write = ~stall;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, writeback bypass, load-use stall,
// flush bubbles, stall counting and reset in the middle of a stall.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] PC_in, Read_Data_1, Read_Data_2, Imm, WB_Data;
  logic [4:0]  rs1, rs2, rd, WB_rd;
  logic [3:0]  Funct4;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc;
  logic [1:0]  ALUOp;
  logic        WB_RegWrite, Flush;
  logic [63:0] EX_PC, EX_Data_1, EX_Data_2, EX_Imm;
  logic [4:0]  EX_rs1, EX_rs2, EX_rd;
  logic [3:0]  EX_Funct4;
  logic [1:0]  EX_ALUOp;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_Branch, EX_ALUSrc;
  logic        EX_valid, Stall, PC_Write, IF_ID_Write;
  logic [31:0] Stall_Count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .PC_in(PC_in), .rs1(rs1), .rs2(rs2), .rd(rd),
    .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .Imm(Imm), .Funct4(Funct4),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .Branch(Branch), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .WB_RegWrite(WB_RegWrite),
    .WB_rd(WB_rd), .WB_Data(WB_Data), .Flush(Flush), .EX_PC(EX_PC),
    .EX_Data_1(EX_Data_1), .EX_Data_2(EX_Data_2), .EX_Imm(EX_Imm), .EX_rs1(EX_rs1),
    .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_Funct4(EX_Funct4), .EX_ALUOp(EX_ALUOp),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_Branch(EX_Branch), .EX_ALUSrc(EX_ALUSrc),
    .EX_valid(EX_valid), .Stall(Stall), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Stall_Count(Stall_Count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ctrl(input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic br, input logic as, input logic [1:0] op);
    RegWrite = rw; MemRead = mr; MemWrite = mw; MemtoReg = m2r;
    Branch = br; ALUSrc = as; ALUOp = op;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " valid"}, {63'd0, EX_valid}, 64'd0);
    chk({tag, " ctrl"}, {56'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg,
                         EX_Branch, EX_ALUSrc, EX_ALUOp}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0;
    PC_in = '0; Read_Data_1 = '0; Read_Data_2 = '0; Imm = '0;
    rs1 = '0; rs2 = '0; rd = '0; Funct4 = '0;
    set_ctrl(0, 0, 0, 0, 0, 0, 2'b00);
    WB_RegWrite = 1'b0; WB_rd = '0; WB_Data = '0;
    tick(); tick();
    chk("rst valid", {63'd0, EX_valid}, 64'd0);
    chk("rst stall", {63'd0, Stall}, 64'd0);
    chk("rst pc_write", {63'd0, PC_Write}, 64'd1);
    chk("rst ifid_write", {63'd0, IF_ID_Write}, 64'd1);
    chk("rst count", {32'd0, Stall_Count}, 64'd0);
    reset = 1'b0;

    // plain R-type capture
    PC_in = 64'h100; rs1 = 5'd3; rs2 = 5'd7; rd = 5'd9;
    Read_Data_1 = 64'h33; Read_Data_2 = 64'h77; Imm = 64'h10; Funct4 = 4'b1000;
    set_ctrl(1, 0, 0, 0, 0, 0, 2'b10);
    tick();
    chk("load data1", EX_Data_1, 64'h33);
    chk("load data2", EX_Data_2, 64'h77);
    chk("load regwrite", {63'd0, EX_RegWrite}, 64'd1);
    chk("load valid", {63'd0, EX_valid}, 64'd1);
    chk("load pc", EX_PC, 64'h100);
    chk("load imm", EX_Imm, 64'h10);
    chk("load regs", {49'd0, EX_rs1, EX_rs2, EX_rd}, {49'd0, 5'd3, 5'd7, 5'd9});
    chk("load funct/op", {58'd0, EX_Funct4, EX_ALUOp}, {58'd0, 4'b1000, 2'b10});

    // writeback bypass on rs2; non-matching rs1 reads the register file
    rs1 = 5'd1; Read_Data_1 = 64'h11; rs2 = 5'd5; Read_Data_2 = 64'h5;
    WB_RegWrite = 1'b1; WB_rd = 5'd5; WB_Data = 64'hDEAD;
    tick();
    chk("bypass data2", EX_Data_2, 64'hDEAD);
    chk("bypass data1 rf", EX_Data_1, 64'h11);

    // matching rd but write disabled: no bypass
    WB_RegWrite = 1'b0;
    tick();
    chk("no wb data2", EX_Data_2, 64'h5);

    // x0 reads as zero even when writeback targets x0
    WB_RegWrite = 1'b1; WB_rd = 5'd0; rs2 = 5'd0; rs1 = 5'd0;
    tick();
    chk("x0 data2", EX_Data_2, 64'd0);
    chk("x0 data1", EX_Data_1, 64'd0);
    WB_RegWrite = 1'b0;

    // load-use: ld x4 then an instruction reading x4
    rs1 = 5'd2; rs2 = 5'd0; rd = 5'd4; PC_in = 64'h200;
    set_ctrl(1, 1, 0, 1, 0, 1, 2'b00);
    tick();
    chk("ld memread", {63'd0, EX_MemRead}, 64'd1);
    rs1 = 5'd4; rd = 5'd8; PC_in = 64'h204; Read_Data_1 = 64'h44;
    set_ctrl(1, 0, 0, 0, 0, 0, 2'b10);
    #1;
    chk("lu stall", {63'd0, Stall}, 64'd1);
    chk("lu pc_write", {63'd0, PC_Write}, 64'd0);
    chk("lu ifid_write", {63'd0, IF_ID_Write}, 64'd0);
    chk("lu count pre", {32'd0, Stall_Count}, 64'd0);
    tick();
    chk_bubble("lu bubble");
    chk("lu bubble data1", EX_Data_1, 64'd0);
    chk("lu stall clear", {63'd0, Stall}, 64'd0);
    chk("lu count", {32'd0, Stall_Count}, 64'd1);
    tick();
    chk("lu resume valid", {63'd0, EX_valid}, 64'd1);
    chk("lu resume rd/pc", {EX_PC[58:0], EX_rd}, {59'h204, 5'd8});
    chk("lu resume count", {32'd0, Stall_Count}, 64'd1);

    // load to x0 never stalls
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    set_ctrl(1, 1, 0, 1, 0, 1, 2'b00);
    tick();
    chk("x0 ld memread", {63'd0, EX_MemRead}, 64'd1);
    chk("x0 ld nostall", {63'd0, Stall}, 64'd0);

    // ld x9, then decode not reading x9
    rs1 = 5'd1; rd = 5'd9;
    tick();
    rs1 = 5'd3; rs2 = 5'd5; rd = 5'd10;
    set_ctrl(1, 0, 0, 0, 0, 0, 2'b10);
    #1;
    chk("ld mismatch nostall", {63'd0, Stall}, 64'd0);

    // rs2 matches x9 together with a flush: flush wins, count still advances
    rs2 = 5'd9; Flush = 1'b1;
    #1;
    chk("flush+stall stall", {63'd0, Stall}, 64'd1);
    tick();
    chk_bubble("flush+stall");
    chk("flush+stall count", {32'd0, Stall_Count}, 64'd2);
    Flush = 1'b0;
    #1;
    chk("post flush stall", {63'd0, Stall}, 64'd0);
    tick();
    chk("post flush valid", {63'd0, EX_valid}, 64'd1);

    // flush without a hazard
    set_ctrl(1, 0, 1, 0, 1, 1, 2'b01);
    Flush = 1'b1;
    tick();
    chk_bubble("flush only");
    chk("flush only count", {32'd0, Stall_Count}, 64'd2);
    Flush = 1'b0;

    // reset asserted while a stall is pending
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd7; Imm = 64'h99; PC_in = 64'h300;
    set_ctrl(1, 1, 0, 1, 0, 1, 2'b00);
    tick();
    rs1 = 5'd7;
    set_ctrl(1, 0, 0, 0, 0, 0, 2'b10);
    #1;
    chk("rst-stall pre", {63'd0, Stall}, 64'd1);
    reset = 1'b1;
    tick();
    chk_bubble("rst-stall");
    chk("rst-stall data", EX_PC | EX_Imm | EX_Data_1 | EX_Data_2, 64'd0);
    chk("rst-stall regs", {49'd0, EX_rs1, EX_rs2, EX_rd}, 64'd0);
    chk("rst-stall count", {32'd0, Stall_Count}, 64'd0);
    chk("rst-stall stall", {63'd0, Stall}, 64'd0);
    chk("rst-stall pc_write", {63'd0, PC_Write}, 64'd1);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
